// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 ALU scheduler: default sizes, command
// codes, response codes, per-port capture states and a round-robin helper.
package calc1_pkg;

   localparam int NPORTS_DEF = 4;
   localparam int DW_DEF     = 32;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   typedef enum logic [1:0] {
      RESP_NONE     = 2'd0,
      RESP_OK       = 2'd1,
      RESP_ERR      = 2'd2,
      RESP_INTERNAL = 2'd3
   } resp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OP2  = 2'd1,
      ST_PEND = 2'd2
   } port_state_e;

   // Port numbers run 1..nports; the successor of the last port wraps to 1.
   function automatic int rr_next(input int idx, input int nports);
      return (idx % nports) + 1;
   endfunction

endpackage

// File: rtl/calc1_alu.sv
// Purely combinational ALU shared by all requester ports. Vectors use
// bit 0 as the MSB, so the shift amount is the last five bits of op2.
module calc1_alu
   import calc1_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [0:3]    cmd,
   input  logic [0:DW-1] op1,
   input  logic [0:DW-1] op2,
   output logic [0:DW-1] result,
   output logic [0:1]    resp
);

   logic [0:DW] sum_ext;
   logic [0:4]  sh_amt;

   // Decode the command; anything unrecognised or out of range reports an error with zero data.
   always_comb begin
      sum_ext = {1'b0, op1} + {1'b0, op2};
      sh_amt  = op2[DW-5:DW-1];
      result  = '0;
      resp    = RESP_ERR;
      case (cmd)
         CMD_ADD: begin
            if (!sum_ext[0]) begin
               result = sum_ext[1:DW];
               resp   = RESP_OK;
            end
         end
         CMD_SUB: begin
            if (op2 <= op1) begin
               result = op1 - op2;
               resp   = RESP_OK;
            end
         end
         CMD_SHL: begin
            result = op1 << sh_amt;
            resp   = RESP_OK;
         end
         CMD_SHR: begin
            result = op1 >> sh_amt;
            resp   = RESP_OK;
         end
         default: begin
            result = '0;
            resp   = RESP_ERR;
         end
      endcase
   end

endmodule

// File: rtl/calc1_alu_sched.sv
// Per-port two-cycle operand capture, round-robin arbitration of pending
// ports onto one shared ALU, and one-cycle registered responses.
module calc1_alu_sched
   import calc1_pkg::*;
#(
   parameter int NPORTS = NPORTS_DEF,
   parameter int DW     = DW_DEF
) (
   input  logic                         c_clk,
   input  logic                         reset,
   input  logic [1:NPORTS][0:3]         req_cmd_in,
   input  logic [1:NPORTS][0:DW-1]      req_data_in,
   output logic [1:NPORTS][0:1]         out_resp,
   output logic [1:NPORTS][0:DW-1]      out_data
);

   localparam int PW = $clog2(NPORTS + 1);

   port_state_e     state    [1:NPORTS];
   logic [0:3]      held_cmd [1:NPORTS];
   logic [0:DW-1]   held_op1 [1:NPORTS];
   logic [0:DW-1]   held_op2 [1:NPORTS];

   logic [PW-1:0]   rr_ptr;
   logic            grant_valid;
   logic [PW-1:0]   grant_idx;
   int              scan_idx;

   logic [0:3]      alu_cmd;
   logic [0:DW-1]   alu_op1;
   logic [0:DW-1]   alu_op2;
   logic [0:DW-1]   alu_result;
   logic [0:1]      alu_resp;

   // Scan ports starting at the round-robin pointer and grant the first one holding both operands.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = rr_ptr;
      scan_idx    = 1;
      for (int k = 0; k < NPORTS; k++) begin
         scan_idx = ((int'(rr_ptr) - 1 + k) % NPORTS) + 1;
         if (!grant_valid && state[scan_idx] == ST_PEND) begin
            grant_valid = 1'b1;
            grant_idx   = PW'(scan_idx);
         end
      end
   end

   // Route the granted port's held command and operands into the shared ALU.
   always_comb begin
      alu_cmd = held_cmd[grant_idx];
      alu_op1 = held_op1[grant_idx];
      alu_op2 = held_op2[grant_idx];
   end

   calc1_alu #(.DW(DW)) u_alu (
      .cmd    (alu_cmd),
      .op1    (alu_op1),
      .op2    (alu_op2),
      .result (alu_result),
      .resp   (alu_resp)
   );

   // Port capture FSMs, round-robin pointer and registered one-cycle responses.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         for (int p = 1; p <= NPORTS; p++) begin
            state[p]    <= ST_IDLE;
            held_cmd[p] <= '0;
            held_op1[p] <= '0;
            held_op2[p] <= '0;
         end
         rr_ptr   <= PW'(1);
         out_resp <= '0;
         out_data <= '0;
      end else begin
         for (int p = 1; p <= NPORTS; p++) begin
            case (state[p])
               ST_IDLE: begin
                  if (req_cmd_in[p] != CMD_NOP) begin
                     held_cmd[p] <= req_cmd_in[p];
                     held_op1[p] <= req_data_in[p];
                     state[p]    <= ST_OP2;
                  end
               end
               ST_OP2: begin
                  held_op2[p] <= req_data_in[p];
                  state[p]    <= ST_PEND;
               end
               ST_PEND: begin
                  if (grant_valid && grant_idx == PW'(p)) begin
                     state[p] <= ST_IDLE;
                  end
               end
               default: begin
                  state[p] <= ST_IDLE;
               end
            endcase
         end

         out_resp <= '0;
         out_data <= '0;
         if (grant_valid) begin
            if (state[grant_idx] != ST_PEND) begin
               out_resp[grant_idx] <= RESP_INTERNAL;
            end else begin
               out_resp[grant_idx] <= alu_resp;
               out_data[grant_idx] <= alu_result;
            end
            rr_ptr <= PW'(rr_next(int'(grant_idx), NPORTS));
         end
      end
   end

endmodule

// File: tb/tb_calc1_alu_sched.sv
// Directed testbench for calc1_alu_sched with a request-level reference
// model compared against the DUT every cycle plus literal spot checks.
module tb_calc1_alu_sched;

   logic              clk;
   logic              reset;
   logic [1:4][0:3]   req_cmd_in;
   logic [1:4][0:31]  req_data_in;
   logic [1:4][0:1]   out_resp;
   logic [1:4][0:31]  out_data;

   int checks;
   int failures;

   logic        model_valid;
   logic        m_has_req [1:4];
   logic        m_has_op2 [1:4];
   logic [3:0]  m_cmd     [1:4];
   logic [31:0] m_op1     [1:4];
   logic [31:0] m_op2     [1:4];
   logic [1:0]  exp_resp  [1:4];
   logic [31:0] exp_data  [1:4];
   int          m_ptr;
   int          m_grant;
   int          m_scan;

   calc1_alu_sched #(.NPORTS(4), .DW(32)) dut (
      .c_clk       (clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic result of one request computed with wide integers: {resp, data}.
   function automatic logic [33:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] wide;
      wide = {32'd0, a} + {32'd0, b};
      case (c)
         4'd1:    return (wide > 64'hFFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, wide[31:0]};
         4'd2:    return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
         4'd5:    return {2'd1, a << (b % 32)};
         4'd6:    return {2'd1, a >> (b % 32)};
         default: return {2'd2, 32'd0};
      endcase
   endfunction

   // Request-level model: each port holds at most one request; a complete request
   // waits until the rotating scan reaches it, and its answer appears the next cycle.
   always @(posedge clk) begin
      if (reset) begin
         for (int p = 1; p <= 4; p++) begin
            m_has_req[p] = 1'b0;
            m_has_op2[p] = 1'b0;
            exp_resp[p]  = 2'd0;
            exp_data[p]  = 32'd0;
         end
         m_ptr       = 1;
         model_valid = 1'b1;
      end else if (model_valid) begin
         m_grant = 0;
         for (int k = 0; k < 4; k++) begin
            m_scan = ((m_ptr - 1 + k) % 4) + 1;
            if (m_grant == 0 && m_has_req[m_scan] && m_has_op2[m_scan]) m_grant = m_scan;
         end
         for (int p = 1; p <= 4; p++) begin
            exp_resp[p] = 2'd0;
            exp_data[p] = 32'd0;
         end
         if (m_grant != 0) begin
            {exp_resp[m_grant], exp_data[m_grant]} = ref_alu(m_cmd[m_grant], m_op1[m_grant], m_op2[m_grant]);
            m_ptr = (m_grant % 4) + 1;
         end
         for (int p = 1; p <= 4; p++) begin
            if (p == m_grant) begin
               m_has_req[p] = 1'b0;
               m_has_op2[p] = 1'b0;
            end else if (m_has_req[p] && !m_has_op2[p]) begin
               m_op2[p]     = req_data_in[p];
               m_has_op2[p] = 1'b1;
            end else if (!m_has_req[p] && req_cmd_in[p] != 4'd0) begin
               m_cmd[p]     = req_cmd_in[p];
               m_op1[p]     = req_data_in[p];
               m_has_req[p] = 1'b1;
            end
         end
      end
   end

   // Compare every port against the model on each falling edge once reset has been seen.
   always @(negedge clk) begin
      if (model_valid) begin
         for (int p = 1; p <= 4; p++) begin
            checks++;
            if (out_resp[p] !== exp_resp[p] || out_data[p] !== exp_data[p]) begin
               failures++;
               $display("[TB] FAIL model_cmp t=%0t port%0d got resp=%0d data=%h want resp=%0d data=%h",
                        $time, p, out_resp[p], out_data[p], exp_resp[p], exp_data[p]);
            end
         end
      end
   end

   // Hard time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleAll();
      req_cmd_in  = '0;
      req_data_in = '0;
   endtask

   task automatic applyStimulus(input int port, input logic [3:0] cmd, input logic [31:0] data);
      req_cmd_in[port]  = cmd;
      req_data_in[port] = data;
   endtask

   task automatic checkOutput(input string name, input int port, input logic [1:0] want_resp, input logic [31:0] want_data);
      checks++;
      if (out_resp[port] !== want_resp || out_data[port] !== want_data) begin
         failures++;
         $display("[TB] FAIL %s port%0d got resp=%0d data=%h want resp=%0d data=%h",
                  name, port, out_resp[port], out_data[port], want_resp, want_data);
      end
   endtask

   // Directed scenarios; each comment's cycle numbers are relative to its own command cycle.
   initial begin
      checks      = 0;
      failures    = 0;
      model_valid = 1'b0;
      m_ptr       = 1;
      reset       = 1'b1;
      idleAll();
      repeat (3) nextCycle();
      for (int p = 1; p <= 4; p++) checkOutput("reset_state", p, 2'd0, 32'd0);
      reset = 1'b0;

      // Port 1 add 5+3, response in cycle 3 for exactly one cycle.
      applyStimulus(1, 4'h1, 32'h0000_0005);
      nextCycle();
      applyStimulus(1, 4'h0, 32'h0000_0003);
      nextCycle();
      idleAll();
      nextCycle();
      checkOutput("add_basic", 1, 2'd1, 32'h0000_0008);
      for (int p = 2; p <= 4; p++) checkOutput("add_basic_others", p, 2'd0, 32'd0);
      nextCycle();
      checkOutput("add_one_cycle", 1, 2'd0, 32'd0);

      // Pointer now favours port 2: add overflow, sub underflow, shift left served in order.
      applyStimulus(2, 4'h1, 32'hFFFF_FFFF);
      applyStimulus(3, 4'h2, 32'h0000_0002);
      applyStimulus(4, 4'h5, 32'h0000_0001);
      nextCycle();
      applyStimulus(2, 4'h0, 32'h0000_0001);
      applyStimulus(3, 4'h0, 32'h0000_0005);
      applyStimulus(4, 4'h0, 32'h0000_0024);
      nextCycle();
      idleAll();
      nextCycle();
      checkOutput("add_overflow", 2, 2'd2, 32'd0);
      nextCycle();
      checkOutput("sub_underflow", 3, 2'd2, 32'd0);
      nextCycle();
      checkOutput("shl_low5", 4, 2'd1, 32'h0000_0010);

      // Invalid cmd 3 on port 1, shift right on port 3, cmd 0xF on port 4.
      applyStimulus(1, 4'h3, 32'h0000_1234);
      applyStimulus(3, 4'h6, 32'h8000_0000);
      applyStimulus(4, 4'hF, 32'h0000_0000);
      nextCycle();
      applyStimulus(1, 4'h0, 32'h0000_0001);
      applyStimulus(3, 4'h0, 32'h0000_003F);
      applyStimulus(4, 4'h0, 32'h0000_0000);
      nextCycle();
      idleAll();
      nextCycle();
      checkOutput("cmd3_invalid", 1, 2'd2, 32'd0);
      nextCycle();
      checkOutput("shr_31", 3, 2'd1, 32'h0000_0001);
      nextCycle();
      checkOutput("cmdF_invalid", 4, 2'd2, 32'd0);

      // Equal-operand subtract on port 2 moves the pointer away from port 1.
      applyStimulus(2, 4'h2, 32'h0000_0007);
      nextCycle();
      applyStimulus(2, 4'h0, 32'h0000_0007);
      nextCycle();
      idleAll();
      nextCycle();
      checkOutput("sub_equal", 2, 2'd1, 32'd0);

      // Reset restores port 1 priority; all four ports add 1+1 together.
      reset = 1'b1;
      nextCycle();
      nextCycle();
      reset = 1'b0;
      for (int p = 1; p <= 4; p++) applyStimulus(p, 4'h1, 32'h0000_0001);
      nextCycle();
      for (int p = 1; p <= 4; p++) applyStimulus(p, 4'h0, 32'h0000_0001);
      nextCycle();
      idleAll();
      nextCycle();
      for (int p = 1; p <= 4; p++) begin
         checkOutput("rr_all_ports", p, 2'd1, 32'h0000_0002);
         nextCycle();
      end

      // Commands during OP2/PEND are ignored; a new command is accepted in the response cycle.
      applyStimulus(1, 4'h1, 32'h0000_000A);
      nextCycle();
      applyStimulus(1, 4'h2, 32'h0000_0014);
      nextCycle();
      applyStimulus(1, 4'h1, 32'h0000_0063);
      nextCycle();
      checkOutput("ignore_busy", 1, 2'd1, 32'h0000_001E);
      applyStimulus(1, 4'h2, 32'h0000_0009);
      nextCycle();
      checkOutput("ignore_no_second", 1, 2'd0, 32'd0);
      applyStimulus(1, 4'h0, 32'h0000_0004);
      nextCycle();
      idleAll();
      checkOutput("back_to_back_wait", 1, 2'd0, 32'd0);
      nextCycle();
      checkOutput("back_to_back", 1, 2'd1, 32'h0000_0005);

      // Reset in cycle 2 of a pending command discards it; inputs during reset are ignored.
      applyStimulus(1, 4'h1, 32'h0000_0001);
      nextCycle();
      applyStimulus(1, 4'h0, 32'h0000_0002);
      nextCycle();
      idleAll();
      reset = 1'b1;
      applyStimulus(2, 4'h1, 32'h0000_0007);
      nextCycle();
      reset = 1'b0;
      idleAll();
      checkOutput("reset_discard", 1, 2'd0, 32'd0);
      nextCycle();
      checkOutput("reset_discard_late", 1, 2'd0, 32'd0);
      nextCycle();
      checkOutput("reset_input_ignored", 2, 2'd0, 32'd0);
      applyStimulus(1, 4'h1, 32'h0000_0004);
      nextCycle();
      applyStimulus(1, 4'h0, 32'h0000_0004);
      nextCycle();
      idleAll();
      nextCycle();
      checkOutput("after_reset_fresh", 1, 2'd1, 32'h0000_0008);

      repeat (3) nextCycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
